// File: rtl/extreme_position_tracker_pkg.sv
// Shared phase-processing definitions: period length, position width and
// extreme-tracker FSM encoding.
package extreme_position_tracker_pkg;

    localparam int unsigned PERIOD_LEN_DEFAULT = 3600;
    localparam int unsigned POS_W              = 12;

    typedef logic [POS_W-1:0] pos_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

endpackage

// File: rtl/extreme_position_tracker_if.sv
// Sample stream in, published extreme positions and status pulses out.
interface extreme_position_tracker_if
    import extreme_position_tracker_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) ();

    logic                     sample_valid;
    logic                     frame_sync;
    logic signed [DATA_W-1:0] average_1_data;
    logic signed [DATA_W-1:0] average_2_data;
    pos_t                     average_1_position_max;
    pos_t                     average_1_position_min;
    pos_t                     average_2_position_max;
    pos_t                     average_2_position_min;
    logic                     init_phase_found_posedge;
    logic                     period_abort;

    modport master (
        output sample_valid, frame_sync, average_1_data, average_2_data,
        input  average_1_position_max, average_1_position_min,
        input  average_2_position_max, average_2_position_min,
        input  init_phase_found_posedge, period_abort
    );

    modport slave (
        input  sample_valid, frame_sync, average_1_data, average_2_data,
        output average_1_position_max, average_1_position_min,
        output average_2_position_max, average_2_position_min,
        output init_phase_found_posedge, period_abort
    );

endinterface

// File: rtl/extreme_position_tracker_extreme_track.sv
// One channel: running signed max/min value and the position where each first occurred.
module extreme_track
    import extreme_position_tracker_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                     alg_clk,
    input  logic                     alg_rst_n,
    input  logic                     i_load,
    input  logic                     i_update,
    input  logic signed [DATA_W-1:0] i_data,
    input  pos_t                     i_pos,
    output pos_t                     o_max_pos_d,
    output pos_t                     o_min_pos_d
);

    logic signed [DATA_W-1:0] r_max_val, r_min_val, w_max_val, w_min_val;
    pos_t                     r_max_pos, r_min_pos, w_max_pos, w_min_pos;

    // Strict compares so a tie keeps the earliest position.
    always_comb begin
        w_max_val = r_max_val;
        w_min_val = r_min_val;
        w_max_pos = r_max_pos;
        w_min_pos = r_min_pos;
        if (i_load) begin
            w_max_val = i_data;
            w_min_val = i_data;
            w_max_pos = '0;
            w_min_pos = '0;
        end else if (i_update) begin
            if (i_data > r_max_val) begin
                w_max_val = i_data;
                w_max_pos = i_pos;
            end
            if (i_data < r_min_val) begin
                w_min_val = i_data;
                w_min_pos = i_pos;
            end
        end
    end

    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            r_max_val <= '0;
            r_min_val <= '0;
            r_max_pos <= '0;
            r_min_pos <= '0;
        end else begin
            r_max_val <= w_max_val;
            r_min_val <= w_min_val;
            r_max_pos <= w_max_pos;
            r_min_pos <= w_min_pos;
        end
    end

    // Next-state view lets the top publish a result that includes the final sample.
    assign o_max_pos_d = w_max_pos;
    assign o_min_pos_d = w_min_pos;

endmodule

// File: rtl/extreme_position_tracker.sv
// Finds the positions of max/min of two sample channels over one phase period
// and publishes them with a one-cycle pulse.
module extreme_position_tracker
    import extreme_position_tracker_pkg::*;
#(
    parameter int unsigned PERIOD_LEN = PERIOD_LEN_DEFAULT,
    parameter int unsigned DATA_W     = 16
) (
    input  logic                        alg_clk,
    input  logic                        alg_rst_n,
    extreme_position_tracker_if.slave   bus
);

    localparam pos_t LAST_POS = pos_t'(PERIOD_LEN - 1);

    logic [1:0] r_state, w_state;
    pos_t       r_cnt, w_cnt, w_pos;
    logic       w_sync, w_load, w_update, w_publish, w_abort;
    logic       r_found, r_abort;
    pos_t       w_max1_d, w_min1_d, w_max2_d, w_min2_d;
    pos_t       r_max1, r_min1, r_max2, r_min2;

    assign w_sync = bus.sample_valid && bus.frame_sync;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_pos     = r_cnt + 1'b1;
        w_load    = 1'b0;
        w_update  = 1'b0;
        w_publish = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_sync) begin
                    w_load = 1'b1;
                    w_cnt  = '0;
                    if (LAST_POS == '0) begin
                        w_publish = 1'b1;
                        w_state   = ST_PUBLISH;
                    end else begin
                        w_state = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (w_sync) begin
                    // Frame sync mid-period: drop the partial period and restart here.
                    w_abort = 1'b1;
                    w_load  = 1'b1;
                    w_cnt   = '0;
                end else if (bus.sample_valid) begin
                    w_update = 1'b1;
                    w_cnt    = w_pos;
                    if (w_pos == LAST_POS) begin
                        w_publish = 1'b1;
                        w_state   = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    extreme_track #(.DATA_W(DATA_W)) u_track_1 (
        .alg_clk     (alg_clk),
        .alg_rst_n   (alg_rst_n),
        .i_load      (w_load),
        .i_update    (w_update),
        .i_data      (bus.average_1_data),
        .i_pos       (w_pos),
        .o_max_pos_d (w_max1_d),
        .o_min_pos_d (w_min1_d)
    );

    extreme_track #(.DATA_W(DATA_W)) u_track_2 (
        .alg_clk     (alg_clk),
        .alg_rst_n   (alg_rst_n),
        .i_load      (w_load),
        .i_update    (w_update),
        .i_data      (bus.average_2_data),
        .i_pos       (w_pos),
        .o_max_pos_d (w_max2_d),
        .o_min_pos_d (w_min2_d)
    );

    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_abort <= 1'b0;
            r_max1  <= '0;
            r_min1  <= '0;
            r_max2  <= '0;
            r_min2  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_found <= w_publish;
            r_abort <= w_abort;
            if (w_publish) begin
                r_max1 <= w_max1_d;
                r_min1 <= w_min1_d;
                r_max2 <= w_max2_d;
                r_min2 <= w_min2_d;
            end
        end
    end

    assign bus.average_1_position_max   = r_max1;
    assign bus.average_1_position_min   = r_min1;
    assign bus.average_2_position_max   = r_max2;
    assign bus.average_2_position_min   = r_min2;
    assign bus.init_phase_found_posedge = r_found;
    assign bus.period_abort             = r_abort;

endmodule

// File: tb/tb_extreme_position_tracker.sv
// Scoreboard bench: stimulus pushes expected publish/abort events, a negedge
// monitor pops and compares whenever a pulse appears.
module tb_extreme_position_tracker;
    import extreme_position_tracker_pkg::*;

    localparam int DATA_W = 16;
    localparam int PL     = 3600;

    logic alg_clk   = 1'b0;
    logic alg_rst_n = 1'b1;
    always #5 alg_clk = ~alg_clk;

    extreme_position_tracker_if #(.DATA_W(DATA_W)) bus ();

    extreme_position_tracker #(.PERIOD_LEN(PL), .DATA_W(DATA_W)) dut (
        .alg_clk   (alg_clk),
        .alg_rst_n (alg_rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic       ab;
        int         cyc;
        logic [11:0] max1;
        logic [11:0] min1;
        logic [11:0] max2;
        logic [11:0] min2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge alg_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int d1, input int d2, input logic fs);
        bus.sample_valid   = 1'b1;
        bus.frame_sync     = fs;
        bus.average_1_data = 16'(d1);
        bus.average_2_data = 16'(d2);
        @(posedge alg_clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.frame_sync   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge alg_clk);
            #1;
        end
    endtask

    // Pulse is expected in the cycle right after the edge that took the last sample.
    task automatic push(input logic ab, input int a, input int b, input int c, input int d);
        exp_t e;
        e.ab   = ab;
        e.cyc  = cyc;
        e.max1 = 12'(a);
        e.min1 = 12'(b);
        e.max2 = 12'(c);
        e.min2 = 12'(d);
        q.push_back(e);
    endtask

    always @(negedge alg_clk) begin
        exp_t e;
        if (bus.init_phase_found_posedge || bus.period_abort) begin
            chk("pulse_exclusive",
                int'(bus.init_phase_found_posedge && bus.period_abort), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse found=%0b abort=%0b at cycle %0d expected none",
                         bus.init_phase_found_posedge, bus.period_abort, cyc);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_abort", int'(bus.period_abort), int'(e.ab));
                chk("event_found", int'(bus.init_phase_found_posedge), int'(!e.ab));
                chk("ch1_max_pos", int'(bus.average_1_position_max), int'(e.max1));
                chk("ch1_min_pos", int'(bus.average_1_position_min), int'(e.min1));
                chk("ch2_max_pos", int'(bus.average_2_position_max), int'(e.max2));
                chk("ch2_min_pos", int'(bus.average_2_position_min), int'(e.min2));
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ch1_max"}, int'(bus.average_1_position_max), 0);
        chk({tag, "_ch1_min"}, int'(bus.average_1_position_min), 0);
        chk({tag, "_ch2_max"}, int'(bus.average_2_position_max), 0);
        chk({tag, "_ch2_min"}, int'(bus.average_2_position_min), 0);
        chk({tag, "_found"},   int'(bus.init_phase_found_posedge), 0);
        chk({tag, "_abort"},   int'(bus.period_abort), 0);
    endtask

    initial begin
        real s;
        int  v;
        bus.sample_valid   = 1'b0;
        bus.frame_sync     = 1'b0;
        bus.average_1_data = '0;
        bus.average_2_data = '0;

        // Asynchronous reset without any clock edge.
        #2 alg_rst_n = 1'b0;
        #1 chk_zero_outputs("reset");
        idle(3);
        alg_rst_n = 1'b1;
        idle(2);

        // Ramps: ch1 rising, ch2 falling.
        for (int i = 0; i < PL; i++) send(i, PL - 1 - i, i == 0);
        push(1'b0, 3599, 0, 0, 3599);
        idle(3);

        // Constant data: ties keep position 0; a frame_sync during PUBLISH is lost.
        for (int i = 0; i < PL; i++) send(77, -77, i == 0);
        push(1'b0, 0, 0, 0, 0);
        send(5, 5, 1'b1);
        for (int i = 0; i < 4; i++) send(i, i, 1'b0);

        // Sine, one sample every third cycle; ch2 is shifted by half a period.
        for (int i = 0; i < PL; i++) begin
            s = $sin(2.0 * 3.14159265358979323846 * real'(i) / 3600.0);
            v = $rtoi(30000.0 * s);
            send(v, -v, i == 0);
            if (i == PL - 1) push(1'b0, 900, 2700, 2700, 900);
            idle(2);
        end

        // frame_sync at position 1000 aborts; the restarted period publishes.
        for (int i = 0; i < 1000; i++) send(i, -i, i == 0);
        for (int j = 0; j < PL; j++) begin
            send(-j, j - 1800, j == 0);
            if (j == 0) push(1'b1, 900, 2700, 2700, 900);
        end
        push(1'b0, 0, 3599, 3599, 0);
        idle(2);

        // Reset after position 2000, then ignored inputs until a real frame_sync.
        for (int i = 0; i <= 2000; i++) send(i, PL - 1 - i, i == 0);
        #2 alg_rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        idle(3);
        alg_rst_n = 1'b1;
        idle(1);
        bus.frame_sync = 1'b1;
        idle(1);
        bus.frame_sync = 1'b0;
        for (int i = 0; i < 5; i++) send(1000 + i, i, 1'b0);
        for (int i = 0; i < PL; i++) send(i, PL - 1 - i, i == 0);
        push(1'b0, 3599, 0, 0, 3599);
        idle(2);

        // Full-scale signed extremes.
        for (int i = 0; i < PL; i++) begin
            send((i == 0) ? -32768 : (i == PL - 1) ? 32767 : -5,
                 (i == 0) ? -32768 : (i == 1800) ? 32767 : 100, i == 0);
        end
        push(1'b0, 3599, 0, 1800, 0);

        idle(5);
        chk("events_outstanding", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
